// File: rtl/conv_weight_loader_if.sv
// Input packet stream for conv_weight_loader: one word per transfer,
// transfer happens when s_valid && s_ready, s_last marks the final word.
interface conv_weight_loader_if #(
  parameter int WEIGHT_WIDTH = 8
);
  logic [WEIGHT_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;

  // Producer side of the packet stream
  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  // Consumer side of the packet stream (the weight loader)
  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/conv_weight_loader.sv
// conv_weight_loader: buffers one weight packet (bias + KERNEL_SIZE weights)
// from a valid/ready stream and replays it as a gap-free burst on the shared
// neuron weight bus. Bursts are addressed round-robin to N_NEURONS neurons via
// one-hot weight_first/weight_last strobes. The neuron port has no
// backpressure, so a burst is never started until the whole packet is held.
module conv_weight_loader #(
  parameter int WEIGHT_WIDTH     = 8,
  parameter int KERNEL_SIZE      = 9,
  parameter int WEIGHT_MEM_ORDER = 5,
  parameter int N_NEURONS        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  conv_weight_loader_if.slave     s_if,
  output logic [WEIGHT_WIDTH-1:0] weight_stream,
  output logic [N_NEURONS-1:0]    weight_first,
  output logic [N_NEURONS-1:0]    weight_last,
  output logic                    busy,
  output logic                    load_done,
  output logic                    pkt_err
);

  localparam int PKT_LEN = KERNEL_SIZE + 1;
  localparam int CW      = $clog2(PKT_LEN);
  localparam int IW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  localparam logic [CW-1:0] LAST_WORD   = CW'(PKT_LEN - 1);
  localparam logic [IW-1:0] LAST_NEURON = IW'(N_NEURONS - 1);

  // Parameter sanity: the kernel must fit the neuron weight memory.
  if (KERNEL_SIZE < 1 || KERNEL_SIZE > (2 ** WEIGHT_MEM_ORDER) || N_NEURONS < 1) begin : g_bad_params
    $error("conv_weight_loader: illegal KERNEL_SIZE/WEIGHT_MEM_ORDER/N_NEURONS combination");
  end

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           wr_cnt_q;
  logic [CW-1:0]           rd_cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    restart_pend_q;
  logic                    done_pend_q;
  logic                    s_ready_q;
  logic                    busy_q;
  logic                    load_done_q;
  logic                    pkt_err_q;
  logic [WEIGHT_WIDTH-1:0] stream_q;
  logic [N_NEURONS-1:0]    first_q;
  logic [N_NEURONS-1:0]    last_q;
  logic [WEIGHT_WIDTH-1:0] wbuf_q [PKT_LEN];

  logic                    xfer_s;
  logic [N_NEURONS-1:0]    sel_s;

  assign xfer_s = s_if.s_valid && s_ready_q;
  assign sel_s  = N_NEURONS'(1'b1) << idx_q;

  assign s_if.s_ready  = s_ready_q;
  assign weight_stream = stream_q;
  assign weight_first  = first_q;
  assign weight_last   = last_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign pkt_err       = pkt_err_q;

  // Packet buffer: capture accepted words while filling (a restart discards the word).
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && xfer_s && !restart) begin
      wbuf_q[wr_cnt_q] <= s_if.s_data;
    end
  end

  // Main FSM: fill/drain the input packet, emit the burst, sequence neurons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FILL;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      idx_q          <= '0;
      restart_pend_q <= 1'b0;
      done_pend_q    <= 1'b0;
      s_ready_q      <= 1'b1;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      pkt_err_q      <= 1'b0;
      stream_q       <= '0;
      first_q        <= '0;
      last_q         <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pkt_err_q   <= 1'b0;
      first_q     <= '0;
      last_q      <= '0;
      done_pend_q <= 1'b0;
      // load_done lands one cycle after the weight_last cycle.
      load_done_q <= done_pend_q;

      case (state_q)
        S_FILL: begin
          if (restart) begin
            idx_q    <= '0;
            wr_cnt_q <= '0;
          end else if (xfer_s) begin
            if (s_if.s_last) begin
              if (wr_cnt_q == LAST_WORD) begin
                state_q   <= S_EMIT;
                rd_cnt_q  <= '0;
                s_ready_q <= 1'b0;
                busy_q    <= 1'b1;
              end else begin
                pkt_err_q <= 1'b1;
              end
              wr_cnt_q <= '0;
            end else if (wr_cnt_q == LAST_WORD) begin
              // Full packet already held and still no s_last: packet too long.
              pkt_err_q <= 1'b1;
              wr_cnt_q  <= '0;
              state_q   <= S_DRAIN;
            end else begin
              wr_cnt_q <= wr_cnt_q + CW'(1);
            end
          end else begin
            wr_cnt_q <= wr_cnt_q;
          end
        end

        S_DRAIN: begin
          if (restart) begin
            idx_q    <= '0;
            wr_cnt_q <= '0;
            state_q  <= S_FILL;
          end else if (xfer_s && s_if.s_last) begin
            state_q <= S_FILL;
          end else begin
            state_q <= S_DRAIN;
          end
        end

        S_EMIT: begin
          stream_q <= wbuf_q[rd_cnt_q];
          if (rd_cnt_q == '0) begin
            first_q <= sel_s;
          end
          if (rd_cnt_q == LAST_WORD) begin
            // Burst complete: the neuron saw its whole packet, so a pending
            // restart can now take effect safely.
            last_q         <= sel_s;
            state_q        <= S_FILL;
            s_ready_q      <= 1'b1;
            busy_q         <= 1'b0;
            rd_cnt_q       <= '0;
            restart_pend_q <= 1'b0;
            if (restart_pend_q || restart) begin
              idx_q <= '0;
            end else if (idx_q == LAST_NEURON) begin
              idx_q       <= '0;
              done_pend_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
            if (restart) begin
              restart_pend_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= S_FILL;
          wr_cnt_q  <= '0;
          rd_cnt_q  <= '0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader (KERNEL_SIZE=3, N_NEURONS=2): a fixed vector
// table for the basic two-neuron load, directed corner sequences, then random
// packets, all scored against a packet-level reference model plus a neuron
// memory model fed from the weight bus.
module tb_conv_weight_loader;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int MO = 5;
  localparam int N  = 2;
  localparam int P  = K + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  logic [W-1:0] weight_stream;
  logic [N-1:0] weight_first;
  logic [N-1:0] weight_last;
  logic busy;
  logic load_done;
  logic pkt_err;

  always #5 clk = ~clk;

  conv_weight_loader_if #(.WEIGHT_WIDTH(W)) s_if ();

  conv_weight_loader #(
    .WEIGHT_WIDTH(W), .KERNEL_SIZE(K), .WEIGHT_MEM_ORDER(MO), .N_NEURONS(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .s_if(s_if),
    .weight_stream(weight_stream), .weight_first(weight_first),
    .weight_last(weight_last), .busy(busy), .load_done(load_done),
    .pkt_err(pkt_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc;

  // Reference model state (packet level, timed in edges since reset).
  int           burst_e;
  int           burst_idx;
  int           err_cyc;
  int           ld_cyc;
  int           idx;
  bit           pend;
  bit           drain;
  logic [W-1:0] hold;
  logic [W-1:0] bw [P];
  logic [W-1:0] pkt [$];

  // Neuron memory model.
  logic [W-1:0] nmem     [N][P];
  logic [W-1:0] exp_nmem [N][P];
  int           nptr [N];
  bit           nact [N];

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         l;
    logic [W-1:0] es;
    logic [N-1:0] ef;
    logic [N-1:0] el;
    logic         er;
    logic         ed;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    burst_e = -1; burst_idx = 0; err_cyc = -1; ld_cyc = -1;
    idx = 0; pend = 1'b0; drain = 1'b0; hold = '0; cyc = 0;
    pkt.delete();
  endtask

  task automatic check_outputs(input string nm);
    logic [W-1:0] es;
    logic [N-1:0] ef, el;
    logic         eb;
    int           k;
    es = hold; ef = '0; el = '0; eb = 1'b0;
    if (burst_e >= 0) begin
      eb = (cyc >= burst_e) && (cyc < burst_e + P);
      k  = cyc - burst_e - 1;
      if (k >= 0 && k < P) begin
        es   = bw[k];
        hold = bw[k];
        if (k == 0)     ef = N'(1) << burst_idx;
        if (k == P - 1) el = N'(1) << burst_idx;
      end
    end
    chk(nm, {weight_stream, weight_first, weight_last, busy, s_if.s_ready, load_done, pkt_err},
            {es, ef, el, eb, !eb, (cyc == ld_cyc), (cyc == err_cyc)});
  endtask

  task automatic neuron_update();
    logic [63:0] got, ex;
    for (int i = 0; i < N; i++) begin
      if (weight_first[i]) begin nact[i] = 1'b1; nptr[i] = 0; end
      if (nact[i] && nptr[i] < P) begin nmem[i][nptr[i]] = weight_stream; nptr[i]++; end
      if (weight_last[i]) begin
        nact[i] = 1'b0;
        got = '0; ex = '0;
        for (int k = 0; k < P; k++) begin
          got[k*W +: W] = nmem[i][k];
          ex[k*W +: W]  = exp_nmem[i][k];
        end
        chk("neuron_mem", got, ex);
      end
    end
  endtask

  // One clock: drive inputs, advance the model to the coming edge, sample after it.
  task automatic step(input logic [W-1:0] d, input logic v, input logic l,
                      input logic rs, output bit acc);
    int e;
    bit emit_edge;
    e = cyc + 1;
    emit_edge = (burst_e >= 0) && (e > burst_e) && (e <= burst_e + P);
    s_if.s_data = d; s_if.s_valid = v; s_if.s_last = l; restart = rs;
    acc = v && !emit_edge;
    if (emit_edge) begin
      if (rs) pend = 1'b1;
      if (e == burst_e + P) begin
        if (pend) idx = 0;
        else if (idx == N - 1) begin idx = 0; ld_cyc = e + 1; end
        else idx = idx + 1;
        pend = 1'b0;
      end
    end else if (rs) begin
      idx = 0; drain = 1'b0; pkt.delete();
    end else if (v) begin
      if (drain) begin
        if (l) drain = 1'b0;
      end else begin
        pkt.push_back(d);
        if (l) begin
          if (pkt.size() == P) begin
            burst_e = e; burst_idx = idx;
            for (int k = 0; k < P; k++) begin bw[k] = pkt[k]; exp_nmem[idx][k] = pkt[k]; end
          end else begin
            err_cyc = e;
          end
          pkt.delete();
        end else if (pkt.size() == P) begin
          err_cyc = e; drain = 1'b1; pkt.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
    check_outputs("cycle");
    neuron_update();
  endtask

  task automatic send(input logic [W-1:0] w [$], input bit toggle);
    int j;
    bit acc, ph;
    j = 0; ph = 1'b0;
    while (j < w.size()) begin
      step(w[j], toggle ? ph : 1'b1, j == w.size() - 1, 1'b0, acc);
      ph = !ph;
      if (acc) j++;
    end
  endtask

  task automatic idle(input int n, input int rs_at);
    bit acc;
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, i == rs_at, acc);
  endtask

  // Watchdog: the run must always end.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] q [$];
    bit acc;
    tbl[0]  = '{8'd5, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{8'd1, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{8'd2, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{8'd3, 1'b1, 1'b1, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{8'd9, 1'b1, 1'b0, 8'd5, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{8'd9, 1'b1, 1'b0, 8'd1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{8'd9, 1'b1, 1'b0, 8'd2, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{8'd9, 1'b1, 1'b0, 8'd3, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[8]  = '{8'd9, 1'b1, 1'b0, 8'd3, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{8'd4, 1'b1, 1'b0, 8'd3, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{8'd5, 1'b1, 1'b0, 8'd3, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{8'd6, 1'b1, 1'b1, 8'd3, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{8'd0, 1'b0, 1'b0, 8'd9, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{8'd0, 1'b0, 1'b0, 8'd4, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{8'd0, 1'b0, 1'b0, 8'd5, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{8'd0, 1'b0, 1'b0, 8'd6, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[16] = '{8'd0, 1'b0, 1'b0, 8'd6, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[17] = '{8'd0, 1'b0, 1'b0, 8'd6, 2'b00, 2'b00, 1'b1, 1'b0};

    for (int i = 0; i < N; i++) begin nact[i] = 1'b0; nptr[i] = 0; end
    rst_n = 1'b0; restart = 1'b0;
    s_if.s_data = '0; s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    rst_n = 1'b1;

    // Two-neuron load from the vector table, s_valid held high.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].d, tbl[i].v, tbl[i].l, 1'b0, acc);
      chk("tbl", {weight_stream, weight_first, weight_last, s_if.s_ready, load_done},
                 {tbl[i].es, tbl[i].ef, tbl[i].el, tbl[i].er, tbl[i].ed});
    end

    // s_valid toggling: burst still contiguous, one cycle after the s_last transfer.
    q = {8'd5, 8'd1, 8'd2, 8'd3};
    send(q, 1'b1);
    idle(P + 2, -1);

    // Restart in FILL, then a short packet, then a good one to neuron 0.
    idle(2, 0);
    q = {8'd7, 8'd1};
    send(q, 1'b0);
    q = {8'd8, 8'd2, 8'd4, 8'd6};
    send(q, 1'b0);
    idle(P + 2, -1);

    // Long packet dropped through its s_last, then normal operation (wraps).
    q = {8'd7, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8};
    send(q, 1'b0);
    q = {8'd1, 8'd2, 8'd3, 8'd4};
    send(q, 1'b0);
    idle(P + 3, -1);

    // Restart in the 2nd EMIT cycle of the last neuron's burst: no load_done.
    q = {8'd11, 8'd12, 8'd13, 8'd14};
    send(q, 1'b0);
    idle(P + 2, -1);
    q = {8'd21, 8'd22, 8'd23, 8'd24};
    send(q, 1'b0);
    idle(P + 3, 1);
    q = {8'd31, 8'd32, 8'd33, 8'd34};
    send(q, 1'b0);
    idle(P + 3, -1);

    // Reset in the middle of a burst.
    q = {8'd41, 8'd42, 8'd43, 8'd44};
    send(q, 1'b0);
    idle(2, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_emit", {weight_stream, weight_first, weight_last, busy, load_done, pkt_err}, '0);
    s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("after_rst");
    rst_n = 1'b1;
    q = {8'd51, 8'd52, 8'd53, 8'd54};
    send(q, 1'b0);
    idle(P + 3, -1);

    // Random packets: mostly good, some short, some long, rare restarts.
    for (int p = 0; p < 150; p++) begin
      int kind, len;
      logic [W-1:0] w;
      logic v, rs;
      kind = $urandom_range(0, 9);
      if (kind < 7)      len = P;
      else if (kind < 9) len = $urandom_range(1, P - 1);
      else               len = $urandom_range(P + 1, P + 3);
      for (int j = 0; j < len; j++) begin
        w = W'($urandom);
        acc = 1'b0;
        while (!acc) begin
          v  = ($urandom_range(0, 3) != 0);
          rs = ($urandom_range(0, 60) == 0);
          step(w, v, j == len - 1, rs, acc);
        end
      end
    end
    idle(P + 4, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
